// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_skid two-entry skid buffer.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int STALL_CNT_W   = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_reg.sv
// WIDTH-bit data register with load enable and asynchronous active-low clear.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid.sv
// Two-entry skid buffer (main + skid register) with fully registered handshakes.
// Optional stall counter output is enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic             main_load;
  logic             skid_load;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  // in_ready is a flop, so gating with it keeps the cycle just after reset idle.
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY: begin
        if (accept) next_state = BUSY;
      end
      BUSY: begin
        if (accept && !out_ready) begin
          next_state = FULL;
        end else if (!accept && out_ready) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) next_state = BUSY;
      end
      default: next_state = EMPTY;
    endcase
  end

  always_comb begin
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: main_load = accept;
      BUSY: begin
        if (accept) begin
          main_load = out_ready;
          skid_load = !out_ready;
        end
      end
      FULL: begin
        main_load      = out_ready;
        main_from_skid = out_ready;
      end
      default: ;
    endcase
  end

  // Handshake outputs come from the next state so that no path runs from out_ready to in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (next_state != FULL);
      out_valid <= (next_state != EMPTY);
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .d     (main_d),
    .q     (out_data)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

`ifdef PIPE_SKID_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid.sv
// Self-checking bench for pipe_skid: queue-based reference model plus directed and random traffic.
module tb_pipe_skid;
  import pipe_pkg::*;

  localparam int WIDTH = 32;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_SKID_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipe_skid #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // Reference model: a FIFO of at most two accepted words; the head is what must be on out_data.
  logic [WIDTH-1:0] mq[$];
  bit               m_ready_en = 1'b0;
  int               m_popped   = 0;
  int               m_stall    = 0;

  always @(negedge rst_n) begin
    mq.delete();
    m_ready_en = 1'b0;
    m_stall    = 0;
  end

  always @(posedge clk) begin : model_step
    bit pop;
    bit push;
    if (rst_n) begin
      pop  = (mq.size() > 0) && out_ready;
      push = in_valid && m_ready_en && (mq.size() < 2);
      if ((mq.size() > 0) && !out_ready && (m_stall < 65535)) m_stall++;
      if (pop) begin
        void'(mq.pop_front());
        m_popped++;
      end
      if (push) mq.push_back(in_data);
      m_ready_en = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("rst_out_data", out_data, 32'd0);
    end else begin
      checkOutput("model_out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
      checkOutput("model_in_ready", {31'd0, in_ready}, {31'd0, (m_ready_en && (mq.size() < 2))});
      if (mq.size() > 0) checkOutput("model_out_data", out_data, mq[0]);
`ifdef PIPE_SKID_STATS_EN
      checkOutput("model_stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    int cyc;
    int dut_out;
    bit acc;
    bit v;

    #1;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset_out_data", out_data, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("release_in_ready_low", {31'd0, in_ready}, 32'd0);
    nextCycle();
    checkOutput("release_in_ready_high", {31'd0, in_ready}, 32'd1);

    // Streaming: one word per cycle, one cycle latency.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, WIDTH'(k), 1'b1);
      nextCycle();
      checkOutput("stream_data", out_data, k);
      checkOutput("stream_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    applyStimulus(1'b0, '0, 1'b1);
    nextCycle();
    checkOutput("stream_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: fill both entries, refuse a third, then drain in order.
    applyStimulus(1'b1, 32'hA, 1'b0);
    nextCycle();
    checkOutput("bp_data_a", out_data, 32'hA);
    checkOutput("bp_ready_busy", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, 32'hB, 1'b0);
    nextCycle();
    checkOutput("bp_ready_full", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_hold_a", out_data, 32'hA);
    applyStimulus(1'b1, 32'hC, 1'b0);
    nextCycle();
    checkOutput("bp_c_refused", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_still_a", out_data, 32'hA);
    applyStimulus(1'b1, 32'hC, 1'b1);
    nextCycle();
    checkOutput("bp_data_b", out_data, 32'hB);
    checkOutput("bp_ready_back", {31'd0, in_ready}, 32'd1);
    nextCycle();
    checkOutput("bp_data_c", out_data, 32'hC);
    applyStimulus(1'b0, '0, 1'b1);
    nextCycle();
    checkOutput("bp_drained", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while FULL.
    applyStimulus(1'b1, 32'h11, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h22, 1'b0);
    nextCycle();
    checkOutput("rst_pre_full", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("async_out_data", out_data, 32'd0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    checkOutput("rerelease_low", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    nextCycle();
    checkOutput("rerelease_high", {31'd0, in_ready}, 32'd1);
    checkOutput("rerelease_empty", {31'd0, out_valid}, 32'd0);

    // Bubbles: alternating in_valid, random out_ready, 1000 words.
    sent    = 0;
    cyc     = 0;
    dut_out = 0;
    while ((sent < 1000) && (cyc < 20000)) begin
      v = ((cyc % 2) == 1);
      applyStimulus(v, WIDTH'($urandom), 1'($urandom_range(0, 1)));
      acc = v && in_ready;
      if (out_valid && out_ready) dut_out++;
      nextCycle();
      if (acc) sent++;
      cyc++;
    end
    checkOutput("bubble_sent", sent, 1000);
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (out_valid && out_ready) dut_out++;
      nextCycle();
    end
    checkOutput("bubble_out_words", dut_out, 1000);
    checkOutput("bubble_empty", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_SKID_STATS_EN
    rst_n = 1'b0;
    #1;
    checkOutput("stats_reset_zero", {16'd0, stall_cnt}, 32'd0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    applyStimulus(1'b1, 32'h5, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0);
    repeat (70000) @(posedge clk);
    nextCycle();
    checkOutput("stats_saturated", {16'd0, stall_cnt}, 32'h0000FFFF);
    repeat (5) nextCycle();
    checkOutput("stats_held", {16'd0, stall_cnt}, 32'h0000FFFF);
    rst_n = 1'b0;
    #1;
    checkOutput("stats_cleared", {16'd0, stall_cnt}, 32'd0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
